// File: rtl/dct_pkg.sv
// Shared constants and helpers for the DCT frame upscaling stage: supported FFT
// lengths, the per-N pre-shift lookup, a length predicate and the error codes.
package dct_pkg;

    localparam logic [11:0] PTS_32   = 12'd32;
    localparam logic [11:0] PTS_64   = 12'd64;
    localparam logic [11:0] PTS_128  = 12'd128;
    localparam logic [11:0] PTS_256  = 12'd256;
    localparam logic [11:0] PTS_512  = 12'd512;
    localparam logic [11:0] PTS_1024 = 12'd1024;
    localparam logic [11:0] PTS_2048 = 12'd2048;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_BADPTS = 2'b01;

    typedef enum logic {StIdle, StInFrame} state_e;

    // True for the FFT lengths the downstream core supports.
    function automatic logic pts_is_valid(input logic [11:0] pts);
        return (pts == PTS_32)  || (pts == PTS_64)  || (pts == PTS_128) ||
               (pts == PTS_256) || (pts == PTS_512) || (pts == PTS_1024) ||
               (pts == PTS_2048);
    endfunction

    // Left shift that cancels the post-FFT per-N right shift; unknown N runs as 2048.
    function automatic logic [1:0] pts_to_shift(input logic [11:0] pts);
        logic [1:0] sh;
        case (pts)
            PTS_2048, PTS_1024: sh = 2'd0;
            PTS_512,  PTS_256:  sh = 2'd1;
            PTS_128,  PTS_64:   sh = 2'd2;
            PTS_32:             sh = 2'd3;
            default:            sh = 2'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/dct_skid_buf.sv
// Two-entry valid/ready register slice. The output register is the primary
// entry; the skid entry absorbs one beat when the consumer stalls. in_ready is
// registered so the upstream path has no combinational dependency on out_ready.
module dct_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             ready_q;
    logic             push, pop;

    // Next-state: refill the output register from the skid first to keep order.
    always_comb begin
        push         = in_valid && ready_q;
        pop          = out_valid_q && out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = push;
                if (push) begin
                    skid_data_d = in_data;
                end
            end else begin
                out_valid_d  = push;
                skid_valid_d = 1'b0;
                if (push) begin
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State registers; ready tracks the skid entry being free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/dct_frame_upscaling.sv
// Builds FFT frames (sop/eop) from an unframed complex sample stream, sign
// extends each sample to the FFT width and pre-shifts it by a per-N factor so
// end-to-end gain is independent of N. Output goes through a 2-entry skid.
// Optional build macro DCT_UPSCALE_STATS_EN adds frame_cnt / err_cnt outputs.
module dct_frame_upscaling
    import dct_pkg::*;
#(
    parameter int unsigned wDataIn  = 16,
    parameter int unsigned wDataOut = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sink_valid,
    output logic                sink_ready,
    input  logic [wDataIn-1:0]  sink_real,
    input  logic [wDataIn-1:0]  sink_imag,
    input  logic [11:0]         fftpts_in,
    output logic                source_valid,
    input  logic                source_ready,
    output logic [1:0]          source_error,
    output logic                source_sop,
    output logic                source_eop,
    output logic [wDataOut-1:0] source_real,
    output logic [wDataOut-1:0] source_imag,
    output logic [11:0]         fftpts_out,
    output logic                frame_err
`ifdef DCT_UPSCALE_STATS_EN
    ,
    output logic [15:0]         frame_cnt,
    output logic [7:0]          err_cnt
`endif
);

    localparam int unsigned PayW = 16 + 2 * wDataOut;

    // Largest pre-shift is 3, so the output must have 3 bits of headroom.
    if (wDataOut < wDataIn + 3) begin : g_bad_width
        $error("dct_frame_upscaling: wDataOut must be >= wDataIn + 3");
    end

    state_e        state_q;
    logic [10:0]   cnt_q;
    logic [11:0]   pts_q;
    logic [1:0]    shift_q;
    logic [1:0]    err_q;
    logic          frame_err_q;

    logic          accept;
    logic          pts_ok;
    logic          beat_sop, beat_eop;
    logic [1:0]    beat_err, beat_shift;
    logic [11:0]   beat_pts;
    logic [wDataOut-1:0] ext_re, ext_im, scl_re, scl_im;
    logic [PayW-1:0]     pay_in, pay_out;

    // Tag the incoming sample: the sop beat uses fftpts_in directly, later beats the latched frame.
    always_comb begin
        accept = sink_valid && sink_ready;
        pts_ok = pts_is_valid(fftpts_in);
        if (state_q == StIdle) begin
            beat_sop   = 1'b1;
            beat_eop   = 1'b0;  // minimum N is 32, so sop and eop never coincide
            beat_pts   = pts_ok ? fftpts_in : PTS_2048;
            beat_shift = pts_to_shift(fftpts_in);
            beat_err   = pts_ok ? ERR_OK : ERR_BADPTS;
        end else begin
            beat_sop   = 1'b0;
            beat_eop   = ({1'b0, cnt_q} == (pts_q - 12'd1));
            beat_pts   = pts_q;
            beat_shift = shift_q;
            beat_err   = err_q;
        end
        ext_re = {{(wDataOut - wDataIn){sink_real[wDataIn-1]}}, sink_real};
        ext_im = {{(wDataOut - wDataIn){sink_imag[wDataIn-1]}}, sink_imag};
        scl_re = ext_re << beat_shift;
        scl_im = ext_im << beat_shift;
        pay_in = {beat_sop, beat_eop, beat_err, beat_pts, scl_re, scl_im};
    end

    // Framing FSM: latch length/shift on sop, count beats, return to idle on eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pts_q       <= '0;
            shift_q     <= '0;
            err_q       <= ERR_OK;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        pts_q       <= beat_pts;
                        shift_q     <= beat_shift;
                        err_q       <= beat_err;
                        cnt_q       <= 11'd1;
                        frame_err_q <= !pts_ok;
                        state_q     <= StInFrame;
                    end
                    StInFrame: begin
                        if (beat_eop) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                endcase
            end
        end
    end

    dct_skid_buf #(
        .Width (PayW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sink_valid),
        .in_ready  (sink_ready),
        .in_data   (pay_in),
        .out_valid (source_valid),
        .out_ready (source_ready),
        .out_data  (pay_out)
    );

    assign {source_sop, source_eop, source_error, fftpts_out, source_real, source_imag} = pay_out;
    assign frame_err = frame_err_q;

`ifdef DCT_UPSCALE_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    // Completed-frame counter (wraps) and bad-length counter (saturates).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (source_valid && source_ready && source_eop) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (frame_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_dct_frame_upscaling.sv
// Self-checking bench for dct_frame_upscaling against a frame-position model.
module tb_dct_frame_upscaling;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic [15:0] sink_real = '0;
    logic [15:0] sink_imag = '0;
    logic [11:0] fftpts_in = '0;
    logic        source_valid;
    logic        source_ready = 1'b0;
    logic [1:0]  source_error;
    logic        source_sop;
    logic        source_eop;
    logic [27:0] source_real;
    logic [27:0] source_imag;
    logic [11:0] fftpts_out;
    logic        frame_err;
`ifdef DCT_UPSCALE_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    dct_frame_upscaling #(
        .wDataIn  (16),
        .wDataOut (28)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts_in    (fftpts_in),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_error (source_error),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .fftpts_out   (fftpts_out),
        .frame_err    (frame_err)
`ifdef DCT_UPSCALE_STATS_EN
        ,
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
`endif
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic [11:0] pts;
        logic [27:0] re;
        logic [27:0] im;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: position within the current frame.
    int         m_pos = 0;
    int         m_n = 0;
    int         m_shift = 0;
    logic [1:0] m_err = 2'b00;

    // Per-tick observations.
    beat_t t_cur, t_obs, t_exp, t_held, t_held_cmp;
    logic  t_got, t_none, t_acc, t_ferr, t_valid, t_ready;
    logic  t_stall_chk;
    logic  t_stalled_prev = 1'b0;

    function automatic int ref_shift(input int n);
        if (n >= 1024) return 0;
        if (n >= 256) return 1;
        if (n >= 64) return 2;
        return 3;
    endfunction

    function automatic bit ref_valid(input int n);
        return (n >= 32) && (n <= 2048) && ((n & (n - 1)) == 0);
    endfunction

    function automatic logic [27:0] ref_scale(input logic [15:0] x, input int sh);
        int v;
        v = int'($signed(x));
        v = v * (1 << sh);
        return v[27:0];
    endfunction

    task automatic model_push(input logic [15:0] re, input logic [15:0] im, input logic [11:0] pts);
        beat_t b;
        if (m_pos == 0) begin
            if (ref_valid(int'(pts))) begin
                m_n   = int'(pts);
                m_err = 2'b00;
            end else begin
                m_n   = 2048;
                m_err = 2'b01;
            end
            m_shift = ref_shift(m_n);
        end
        b.sop = (m_pos == 0);
        b.eop = (m_pos == m_n - 1);
        b.err = m_err;
        b.pts = m_n[11:0];
        b.re  = ref_scale(re, m_shift);
        b.im  = ref_scale(im, m_shift);
        exp_q.push_back(b);
        m_pos = (m_pos == m_n - 1) ? 0 : m_pos + 1;
    endtask

    // One clock: drive after the edge, observe handshakes mid-cycle.
    task automatic tick(input logic v, input logic [15:0] re, input logic [15:0] im,
                        input logic [11:0] pts, input logic rdy);
        sink_valid   = v;
        sink_real    = re;
        sink_imag    = im;
        fftpts_in    = pts;
        source_ready = rdy;
        @(negedge clk);
        t_cur   = {source_sop, source_eop, source_error, fftpts_out, source_real, source_imag};
        t_valid = source_valid;
        t_ready = sink_ready;
        t_ferr  = frame_err;
        t_got   = 1'b0;
        t_none  = 1'b0;
        t_acc   = 1'b0;
        t_stall_chk    = t_stalled_prev;
        t_held_cmp     = t_held;
        t_stalled_prev = source_valid && !source_ready;
        t_held         = t_cur;
        if (source_valid && source_ready) begin
            t_got = 1'b1;
            t_obs = t_cur;
            if (exp_q.size() == 0) begin
                t_none = 1'b1;
                t_exp  = '0;
            end else begin
                t_exp = exp_q.pop_front();
            end
        end
        if (sink_valid && sink_ready) begin
            t_acc = 1'b1;
            model_push(re, im, pts);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({source_valid, source_sop, source_eop, source_error, source_real, source_imag,
             fftpts_out, frame_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b sop=%b re=%h pts=%h want all zero",
                     source_valid, source_sop, source_real, fftpts_out);
        end
        n_cmp++;
        if (sink_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0", sink_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (sink_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: got %b want 0", sink_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (sink_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_edge: got %b want 1", sink_ready);
        end
    endtask

    task automatic test_back_to_back_2048();
        int acc = 0, k = 0, nb = 0, gaps = 0;
        while (k < 2200 && (acc < 2048 || exp_q.size() != 0)) begin
            tick(acc < 2048, 16'h0001, 16'hFFFF, 12'd2048, 1'b1);
            if (t_acc) acc++;
            if (t_got) begin
                n_cmp++;
                if (t_none || t_obs !== t_exp) begin
                    n_bad++;
                    $display("FAIL beat_2048: got %h want %h none=%b", t_obs, t_exp, t_none);
                end
                if (nb == 0) begin
                    n_cmp++;
                    if (!t_obs.sop || t_obs.re !== 28'h0000001 || t_obs.im !== 28'hFFFFFFF || k != 1)
                    begin
                        n_bad++;
                        $display("FAIL first_beat_2048: got %h at tick %0d want sop re=1 im=-1 tick 1",
                                 t_obs, k);
                    end
                end
                nb++;
            end else if (k >= 1 && nb < 2048) begin
                gaps++;
            end
            k++;
        end
        n_cmp++;
        if (nb != 2048 || gaps != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL count_2048: got beats=%0d gaps=%0d left=%0d want 2048/0/0",
                     nb, gaps, exp_q.size());
        end
    endtask

    task automatic test_n32_extremes();
        int acc = 0, k = 0, nb = 0;
        while (k < 100 && (acc < 32 || exp_q.size() != 0)) begin
            tick(acc < 32, 16'h7FFF, 16'h8000, 12'd32, 1'b1);
            if (t_acc) acc++;
            if (t_got) begin
                n_cmp++;
                if (t_none || t_obs !== t_exp) begin
                    n_bad++;
                    $display("FAIL beat_32: got %h want %h none=%b", t_obs, t_exp, t_none);
                end
                if (nb == 0) begin
                    n_cmp++;
                    if (t_obs.re !== 28'h003FFF8 || t_obs.im !== 28'hFFC0000) begin
                        n_bad++;
                        $display("FAIL scale_32: got re=%h im=%h want 003fff8 ffc0000",
                                 t_obs.re, t_obs.im);
                    end
                end
                if (nb == 31) begin
                    n_cmp++;
                    if (t_obs.eop !== 1'b1) begin
                        n_bad++;
                        $display("FAIL eop_32: got %b want 1", t_obs.eop);
                    end
                end
                nb++;
            end
            k++;
        end
        n_cmp++;
        if (nb != 32 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL count_32: got %0d want 32", nb);
        end
    endtask

    task automatic test_pts_change_midframe();
        int acc = 0, k = 0, nb = 0, nsop = 0;
        logic [11:0] prev_pts = '0, pts;
        logic [11:0] sop_pts[2];
        logic [15:0] re = '0, im = '0;
        sop_pts[0] = '0;
        sop_pts[1] = '0;
        while (k < 700 && (acc < 576 || exp_q.size() != 0)) begin
            if (acc < 100) pts = 12'd512;
            else pts = 12'd64;
            tick(acc < 576, re, im, pts, 1'b1);
            if (t_acc) begin
                acc++;
                re = 16'($urandom);
                im = 16'($urandom);
            end
            if (t_got) begin
                n_cmp++;
                if (t_none || t_obs !== t_exp) begin
                    n_bad++;
                    $display("FAIL beat_switch: got %h want %h none=%b", t_obs, t_exp, t_none);
                end
                if (!t_obs.sop && nb > 0) begin
                    n_cmp++;
                    if (t_obs.pts !== prev_pts) begin
                        n_bad++;
                        $display("FAIL pts_hold: got %0d want %0d", t_obs.pts, prev_pts);
                    end
                end
                if (t_obs.sop && nsop < 2) begin
                    sop_pts[nsop] = t_obs.pts;
                    nsop++;
                end
                prev_pts = t_obs.pts;
                nb++;
            end
            k++;
        end
        n_cmp++;
        if (nsop != 2 || sop_pts[0] !== 12'd512 || sop_pts[1] !== 12'd64 || nb != 576) begin
            n_bad++;
            $display("FAIL frames_switch: got sops=%0d pts=%0d,%0d beats=%0d want 2 512,64 576",
                     nsop, sop_pts[0], sop_pts[1], nb);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0, k = 0, nb = 0, not_ready = 0;
        logic [15:0] im = 16'($urandom);
        while (k < 900 && (acc < 256 || exp_q.size() != 0)) begin
            tick(acc < 256, acc[15:0], im, 12'd256, (k % 3) == 0);
            if (t_acc) begin
                acc++;
                im = 16'($urandom);
            end
            if (!t_ready) not_ready++;
            if (t_stall_chk) begin
                n_cmp++;
                if (!t_valid || t_cur !== t_held_cmp) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid=%b %h want 1 %h", t_valid, t_cur, t_held_cmp);
                end
            end
            if (t_got) begin
                n_cmp++;
                if (t_none || t_obs !== t_exp) begin
                    n_bad++;
                    $display("FAIL beat_bp: got %h want %h none=%b", t_obs, t_exp, t_none);
                end
                nb++;
            end
            k++;
        end
        n_cmp++;
        if (nb != 256 || not_ready == 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL count_bp: got beats=%0d ready_low=%0d want 256 and >0", nb, not_ready);
        end
    endtask

    task automatic test_bad_pts();
        int acc = 0, k = 0, nb = 0, n_e1 = 0, n_e0 = 0, pulses = 0;
        int first_acc_k = -1, pulse_k = -1;
        logic [11:0] pts;
        logic [15:0] re = 16'($urandom), im = 16'($urandom);
        while (k < 6000 && (acc < 3072 || exp_q.size() != 0)) begin
            pts = (acc < 2048) ? 12'd100 : 12'd1024;
            tick((acc < 3072) && ($urandom_range(0, 3) != 0), re, im, pts, 1'b1);
            if (t_ferr) begin
                pulses++;
                if (pulse_k < 0) pulse_k = k;
            end
            if (t_acc) begin
                if (first_acc_k < 0) first_acc_k = k;
                acc++;
                re = 16'($urandom);
                im = 16'($urandom);
            end
            if (t_got) begin
                n_cmp++;
                if (t_none || t_obs !== t_exp) begin
                    n_bad++;
                    $display("FAIL beat_badpts: got %h want %h none=%b", t_obs, t_exp, t_none);
                end
                if (t_obs.err == 2'b01 && t_obs.pts == 12'd2048) n_e1++;
                if (t_obs.err == 2'b00 && t_obs.pts == 12'd1024) n_e0++;
                nb++;
            end
            k++;
        end
        n_cmp++;
        if (pulses != 1 || pulse_k != first_acc_k + 1) begin
            n_bad++;
            $display("FAIL frame_err: got pulses=%0d at %0d want 1 at %0d",
                     pulses, pulse_k, first_acc_k + 1);
        end
        n_cmp++;
        if (n_e1 != 2048 || n_e0 != 1024 || nb != 3072) begin
            n_bad++;
            $display("FAIL err_frames: got err01=%0d err00=%0d beats=%0d want 2048 1024 3072",
                     n_e1, n_e0, nb);
        end
    endtask

    task automatic test_reset_midframe();
        int acc = 0, k = 0, nb = 0;
        logic first_sop = 1'b0;
        logic [15:0] re = 16'($urandom), im = 16'($urandom);
        while (k < 50 && acc < 10) begin
            tick(1'b1, re, im, 12'd128, 1'b1);
            if (t_acc) acc++;
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({source_valid, source_sop, source_eop, source_error, source_real, source_imag,
             fftpts_out, frame_err, sink_ready} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%b re=%h pts=%h ready=%b want all zero",
                     source_valid, source_real, fftpts_out, sink_ready);
        end
        exp_q.delete();
        m_pos = 0;
        t_stalled_prev = 1'b0;
        sink_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        acc = 0;
        k = 0;
        while (k < 400 && (acc < 128 || exp_q.size() != 0)) begin
            tick(acc < 128, re, im, 12'd128, 1'($urandom_range(0, 1)));
            if (t_acc) begin
                acc++;
                re = 16'($urandom);
                im = 16'($urandom);
            end
            if (t_got) begin
                n_cmp++;
                if (t_none || t_obs !== t_exp) begin
                    n_bad++;
                    $display("FAIL beat_after_rst: got %h want %h none=%b", t_obs, t_exp, t_none);
                end
                if (nb == 0) first_sop = t_obs.sop;
                nb++;
            end
            k++;
        end
        n_cmp++;
        if (first_sop !== 1'b1 || nb != 128) begin
            n_bad++;
            $display("FAIL restart_128: got sop=%b beats=%0d want 1 128", first_sop, nb);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back_2048();
        test_n32_extremes();
        test_pts_change_midframe();
        test_backpressure();
        test_bad_pts();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
